// File: rtl/datapath_pkg.sv
// Shared datapath definitions.
//
// Purpose: constants and types shared by the 8x16 register file and the
// blocks that sit around it (such as regfile_reader).
//   DW          register data width
//   NREG        number of registers (fixed at 8, 3-bit index)
//   regidx_t    register index type
//   rdr_state_t readback engine state encoding
//   clamp_count limits a requested burst length to NREG
package datapath_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;

  typedef logic [2:0] regidx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } rdr_state_t;

  // A burst can never cover more than the whole file.
  function automatic logic [3:0] clamp_count(input logic [3:0] c);
    if (c > 4'(NREG)) return 4'(NREG);
    return c;
  endfunction

endpackage

// File: rtl/regfile_reader.sv
// regfile_reader: sequential readback engine for the 8x16 register file.
//
// Walks a contiguous, wrapping range of registers through the file's read
// port and streams each captured value out on a valid/ready interface.
// The engine owns readnum whenever busy is high and never writes the file.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      readback request, sampled only in IDLE
//   first      first register index, sampled with start
//   count      burst length; 0 ignores the request, >8 clamps to 8
//   readnum    register file read select
//   rd_data    register file data_out (combinational from readnum)
//   out_data   captured register value
//   out_idx    index the value was read from
//   out_last   final element of the burst
//   out_valid  output valid
//   out_ready  output ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last handshake
module regfile_reader
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  regidx_t       first,
  input  logic [3:0]    count,
  output regidx_t       readnum,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output regidx_t       out_idx,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  rdr_state_t state;
  logic [3:0] remaining;
  logic       handshake;

  assign handshake = out_valid & out_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      readnum   <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (count != 4'd0)) begin
            readnum   <= first;
            remaining <= clamp_count(count);
            state     <= ADDR;
          end
        end
        // Settle cycle: readnum has just changed, give the read mux a full
        // cycle before sampling rd_data.
        ADDR: state <= CAP;
        CAP: begin
          out_data  <= rd_data;
          out_idx   <= readnum;
          out_last  <= (remaining == 4'd1);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        // Output fields are only written in CAP, so they hold steady here
        // for as long as the consumer stalls.
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (remaining == 4'd1) begin
              done      <= 1'b1;
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining - 4'd1;
              readnum   <= readnum + 3'd1;  // wraps 7 -> 0
              state     <= ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader with a scoreboard of expected beats.
module tb_regfile_reader;
  import datapath_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  regidx_t       first;
  logic [3:0]    count;
  regidx_t       readnum;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  regidx_t       out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NREG];

  typedef struct packed {
    logic [DW-1:0] d;
    logic [2:0]    i;
    logic          l;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file read port.
  assign rd_data = regs[readnum];

  regfile_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .count     (count),
    .readnum   (readnum),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare each beat at the negedge before the handshake edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_extra_beat", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("beat_data", 32'(out_data), 32'(e.d));
        chk("beat_idx",  32'(out_idx),  32'(e.i));
        chk("beat_last", 32'(out_last), 32'(e.l));
      end
    end
  end

  // Push the expected beats, then pulse start; returns #1 after accept edge.
  task automatic start_req(input logic [2:0] f, input logic [3:0] c);
    int n;
    logic [2:0] ix;
    n = (c > 4'd8) ? 8 : int'(c);
    for (int k = 0; k < n; k++) begin
      ix = f + 3'(k);
      sbq.push_back({regs[ix], ix, (k == n - 1)});
    end
    start = 1'b1;
    first = f;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    if (n > 0) chk("readnum_after_accept", 32'(readnum), 32'(f));
  endtask

  task automatic wait_done(input int exp_lat);
    while (!done && (cyc - t0) < 400) begin
      @(posedge clk);
      #1;
    end
    chk("done_latency", 32'(cyc - t0), 32'(exp_lat));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  logic [DW-1:0] hold_d;
  regidx_t       hold_i;
  int            done_seen;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    first = '0;
    count = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NREG; k++) regs[k] = 16'(k * 7 + 3);
    #1;
    chk("rst_readnum",   32'(readnum),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read.
    regs[3] = 16'd42;
    start_req(3'd3, 4'd1);
    wait_done(3);

    // Full dump.
    for (int k = 0; k < NREG; k++) regs[k] = 16'h1000 + 16'(k);
    start_req(3'd0, 4'd8);
    wait_done(24);

    // Wrap and clamp.
    for (int k = 0; k < NREG; k++) regs[k] = 16'h2200 + 16'(k * 3);
    regs[7] = 16'hFF98;
    start_req(3'd7, 4'd15);
    wait_done(24);

    // Back-pressure during beat 2.
    for (int k = 0; k < NREG; k++) regs[k] = 16'hA000 + 16'(k * 17);
    start_req(3'd4, 4'd4);
    while (!(out_valid && out_idx == 3'd5) && (cyc - t0) < 100) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    hold_d = out_data;
    hold_i = out_idx;
    chk("bp_beat2_idx", 32'(hold_i), 32'd5);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_data_hold",  32'(out_data),  32'(hold_d));
      chk("bp_idx_hold",   32'(out_idx),   32'(hold_i));
    end
    out_ready = 1'b1;
    wait_done(17);

    // Ignored request: count = 0.
    start = 1'b1;
    first = 3'd2;
    count = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("cnt0_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("cnt0_busy_later", 32'(busy), 32'd0);

    // Start pulse mid-burst has no effect.
    for (int k = 0; k < NREG; k++) regs[k] = 16'h5150 + 16'(k);
    start_req(3'd2, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    first = 3'd6;
    count = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(9);

    // Reset mid-burst.
    start_req(3'd0, 4'd8);
    while (!out_valid && (cyc - t0) < 100) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_in_send", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",   32'(out_valid), 32'd0);
    chk("rst_mid_busy",    32'(busy),      32'd0);
    chk("rst_mid_readnum", 32'(readnum),   32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int s = 0; s < 30; s++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    chk("rst_mid_no_done", 32'(done_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
# regfile_reader

Sequential readback engine for the 8×16 datapath register file. It walks a contiguous, wrapping range of registers through the file's read port (`readnum` → `data_out`) and streams each captured value out over a valid/ready interface. It is the consumer-side counterpart to the file's write port, used for debug dumps, context save and bench self-checking. It sits beside `regfile`, owns `readnum` whenever `busy` is high, and never drives the write port.

## Interface
- `DW`, 16, register data width
- `NREG`, 8, number of registers; fixed at 8, so indices are 3 bits
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a readback; sampled only in IDLE
- `first`  in  3  first register index, sampled with `start`
- `count`  in  4  number of registers to read; 0 ignores the request, values above 8 clamp to 8
- `readnum`  out  3  drives the register file read select
- `rd_data`  in  DW  register file `data_out`; combinational from `readnum`
- `out_data`  out  DW  captured register value
- `out_idx`  out  3  index the value was read from
- `out_last`  out  1  marks the final element of the burst
- `out_valid`  out  1  output handshake valid
- `out_ready`  in  1  output handshake ready
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last handshake

## Operation
- **States:**
  - IDLE: start with a nonzero count → ADDR. Otherwise stay in IDLE.
  - ADDR: unconditional → CAP. This is the settle cycle for the combinational read mux.
  - CAP: capture `rd_data`, set `out_valid` → SEND.
  - SEND: hold until `out_valid & out_ready`. On the handshake, if `remaining == 1` pulse `done` → IDLE. Otherwise decrement `remaining`, set `readnum <= readnum + 1` (mod 8) → ADDR.
- **Request latch:** on accept, `readnum <= first` and `remaining <= min(count, 8)`.
- **Wrap-around:** the index wraps 7→0. `first=6, count=4` reads R6, R7, R0, R1.
- **Output fields:** `out_idx` equals the `readnum` value at the capture edge. `out_last` is high when `remaining == 1`.
- **Output stability:** `out_data`, `out_idx` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.
- **Ignored inputs:** `start` is ignored while `busy` is high. `first` and `count` are don't-care outside an accepted start.
- **Concurrent writes:** each value reflects the register contents at its CAP edge. A write to a register already captured does not change `out_data`.

## Timing
- **Reset values:** state IDLE, `readnum` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `out_valid` 0, `busy` 0, `done` 0, `remaining` 0.
- **Start latency:** `start` is accepted at edge N. `readnum` is valid after edge N, the capture is at edge N+2, and `out_valid` is high from edge N+2.
- **Burst throughput:** with `out_ready` tied high, one element every 3 cycles, so an 8-register dump takes 24 cycles from accept to `done`.
- **Back-pressure:** `out_ready` low stalls in SEND indefinitely with no data loss.
- **`done` timing:** asserted for exactly the cycle after the final handshake edge, coincident with the return to IDLE and `busy` falling. A new `start` is accepted on that same edge.
- **Reset mid-burst:** everything returns immediately (asynchronously) to the reset values. There is no partial-burst completion and no `done`.

## Structure
- **Shared package `datapath_pkg`:** holds the `DW` and `NREG` constants, the `regidx_t` 3-bit typedef and the `rdr_state_t` enum (IDLE, ADDR, CAP, SEND). The register file and future datapath blocks use the same package.
- **Sub-modules:** none. The block is a single module with FSM, index counter, remaining counter and output register. The register file is instantiated beside it, never inside.

## Test plan
1. **Single read:** preload R3 = 42, then `start`, `first=3`, `count=1`, `out_ready=1` → one beat with `out_data=42`, `out_idx=3`, `out_last=1`; `done` pulses 3 cycles after accept.
2. **Full dump:** preload Rk = 0x1000+k, then `first=0`, `count=8` → 8 beats, indices 0..7, data 0x1000..0x1007, `out_last` only on the 8th, `done` at cycle 24.
3. **Wrap and clamp:** R7 = 65432 (0xFF98), then `first=7`, `count=15` → clamped to 8 beats; the first beat is 0xFF98 at index 7 and the second is at index 0.
4. **Back-pressure:** `out_ready` low for 5 cycles during beat 2 → `out_data` and `out_idx` stay stable, no beat is skipped or duplicated, and total length is unchanged.
5. **Ignored requests:** `count=0` → `busy` stays 0. A `start` pulse mid-burst → no effect on the sequence.
6. **Reset mid-burst:** `rst_n` low during SEND → `out_valid`, `busy` and `readnum` go to 0 immediately and no `done` pulse follows.
